// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state type, size helpers and saturating add for systolic_tile_engine.
package systolic_pkg;
    typedef enum logic [1:0] {IDLE, LOAD_W, COMPUTE, FLUSH} state_t;
    localparam int SAT_W = 64;
    function automatic int groups_of(input int cols, input int out_cols);
        return cols / out_cols;
    endfunction
    function automatic int lat_of(input int rows, input int cols);
        return rows + cols - 1;
    endfunction
    function automatic int grp_w_of(input int groups);
        return groups > 1 ? $clog2(groups) : 1;
    endfunction
    // Operands arrive sign-extended to SAT_W; the sum is clamped to the signed sw-bit range.
    function automatic logic signed [SAT_W-1:0] sat_add(input logic signed [SAT_W-1:0] a,
                                                        input logic signed [SAT_W-1:0] b,
                                                        input int sw);
        logic signed [SAT_W:0] s, one, hi, lo;
        one = {{SAT_W{1'b0}}, 1'b1};
        s = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        hi = (one << (sw - 1)) - one;
        lo = ~hi;
        return s > hi ? hi[SAT_W-1:0] : s < lo ? lo[SAT_W-1:0] : s[SAT_W-1:0];
    endfunction
endpackage

// File: rtl/ws_pe.sv
// ws_pe: weight-stationary cell; holds one weight, passes pixels east and partial sums south.
// SYSTOLIC_ACC_SAT_EN selects saturating accumulation, otherwise sums wrap.
module ws_pe
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SUM_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  w_load,
    input  logic [DATA_WIDTH-1:0] w_in,
    output logic [DATA_WIDTH-1:0] w_out,
    input  logic [DATA_WIDTH-1:0] x_in,
    output logic [DATA_WIDTH-1:0] x_out,
    input  logic [SUM_WIDTH-1:0]  psum_in,
    output logic [SUM_WIDTH-1:0]  psum_out
);
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic [SUM_WIDTH-1:0] prod_ext, sum;
    assign prod = $signed(x_in) * $signed(w_out);
    assign prod_ext = SUM_WIDTH'(prod);
`ifdef SYSTOLIC_ACC_SAT_EN
    assign sum = SUM_WIDTH'(sat_add(SAT_W'($signed(psum_in)), SAT_W'($signed(prod_ext)), SUM_WIDTH));
`else
    assign sum = psum_in + prod_ext;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_out <= '0;
            x_out <= '0;
            psum_out <= '0;
        end else begin
            if (w_load) w_out <= w_in;
            if (tick) begin
                x_out <= x_in;
                psum_out <= sum;
            end
        end
    end
endmodule

// File: rtl/systolic_tile_engine.sv
// systolic_tile_engine: weight-stationary systolic array with skew/deskew and grouped result output.
// SYSTOLIC_ACC_SAT_EN selects saturating PE accumulation.
module systolic_tile_engine
    import systolic_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int DATA_WIDTH = 8,
    parameter int SUM_WIDTH  = 32,
    parameter int OUT_COLS   = 4,
    localparam int GROUPS    = groups_of(COLS, OUT_COLS),
    localparam int LAT       = lat_of(ROWS, COLS),
    localparam int GW        = grp_w_of(GROUPS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    input  logic                          w_valid,
    output logic                          w_ready,
    input  logic [COLS*DATA_WIDTH-1:0]    w_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0]    in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_COLS*SUM_WIDTH-1:0] out_data,
    output logic [GW-1:0]                 out_group,
    output logic                          out_last
);
    localparam int RCW = ROWS > 1 ? $clog2(ROWS) : 1;
    state_t state;
    logic [RCW-1:0] row_cnt;
    logic res_full, res_last;
    logic [GW-1:0] grp;
    logic [LAT-1:0] v_pipe, l_pipe;
    logic [COLS-1:0][SUM_WIDTH-1:0] res_data, col_out;
    logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] x_lnk, w_lnk;
    logic [ROWS-1:0][COLS-1:0][SUM_WIDTH-1:0] ps_lnk;
    logic [ROWS-1:0][DATA_WIDTH-1:0] x_row;
    logic final_hs, tick_ok, tick, w_load, capture;
    logic unused_tail;

    // A tick may only run if the result register can take whatever emerges this cycle.
    assign final_hs = res_full && out_ready && grp == GW'(GROUPS-1);
    assign tick_ok = !res_full || final_hs;
    assign in_ready = state == COMPUTE && tick_ok;
    assign tick = (in_ready && in_valid) || (state == FLUSH && tick_ok);
    assign w_ready = state == LOAD_W;
    assign w_load = w_ready && w_valid;
    assign busy = state != IDLE;
    assign capture = tick && v_pipe[LAT-1];
    assign out_valid = res_full;
    assign out_group = grp;
    assign out_last = res_full && res_last && grp == GW'(GROUPS-1);
    assign out_data = res_data[int'(grp)*OUT_COLS +: OUT_COLS];
    assign unused_tail = ^{x_lnk, w_lnk};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            row_cnt <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) state <= LOAD_W;
                LOAD_W: if (w_valid) begin
                    row_cnt <= row_cnt == RCW'(ROWS-1) ? '0 : row_cnt + 1'b1;
                    if (row_cnt == RCW'(ROWS-1)) state <= COMPUTE;
                end
                COMPUTE: if (in_valid && in_ready && in_last) state <= FLUSH;
                FLUSH: if (v_pipe == '0 && !res_full) begin
                    state <= IDLE;
                    done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_pipe <= '0;
            l_pipe <= '0;
        end else if (tick) begin
            v_pipe <= LAT'({v_pipe, state == COMPUTE});
            l_pipe <= LAT'({l_pipe, state == COMPUTE && in_last});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data <= '0;
            res_full <= 1'b0;
            res_last <= 1'b0;
            grp <= '0;
        end else if (capture) begin
            res_data <= col_out;
            res_full <= 1'b1;
            res_last <= l_pipe[LAT-1];
            grp <= '0;
        end else if (res_full && out_ready) begin
            res_full <= grp != GW'(GROUPS-1);
            grp <= grp == GW'(GROUPS-1) ? '0 : grp + 1'b1;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        logic [DATA_WIDTH-1:0] x_src;
        assign x_src = state == FLUSH ? '0 : in_data[r*DATA_WIDTH +: DATA_WIDTH];
        if (r == 0) begin : g_direct
            assign x_row[r] = x_src;
        end else begin : g_dly
            logic [r-1:0][DATA_WIDTH-1:0] sk;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) sk <= '0;
                else if (tick) begin
                    sk[0] <= x_src;
                    for (int k = 1; k < r; k++) sk[k] <= sk[k-1];
                end
            end
            assign x_row[r] = sk[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_deskew
        if (c == COLS-1) begin : g_direct
            assign col_out[c] = ps_lnk[ROWS-1][c];
        end else begin : g_dly
            localparam int D = COLS - 1 - c;
            logic [D-1:0][SUM_WIDTH-1:0] dq;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) dq <= '0;
                else if (tick) begin
                    dq[0] <= ps_lnk[ROWS-1][c];
                    for (int k = 1; k < D; k++) dq[k] <= dq[k-1];
                end
            end
            assign col_out[c] = dq[D-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_pe
            logic [DATA_WIDTH-1:0] w_src, x_src;
            logic [SUM_WIDTH-1:0] p_src;
            if (r == 0) begin : g_top
                assign w_src = w_data[c*DATA_WIDTH +: DATA_WIDTH];
                assign p_src = '0;
            end else begin : g_mid
                assign w_src = w_lnk[r-1][c];
                assign p_src = ps_lnk[r-1][c];
            end
            if (c == 0) begin : g_west
                assign x_src = x_row[r];
            end else begin : g_east
                assign x_src = x_lnk[r][c-1];
            end
            ws_pe #(.DATA_WIDTH(DATA_WIDTH), .SUM_WIDTH(SUM_WIDTH)) u_pe (
                .clk(clk),
                .rst(rst),
                .tick(tick),
                .w_load(w_load),
                .w_in(w_src),
                .w_out(w_lnk[r][c]),
                .x_in(x_src),
                .x_out(x_lnk[r][c]),
                .psum_in(p_src),
                .psum_out(ps_lnk[r][c])
            );
        end
    end
endmodule

// File: tb/tb_systolic_tile_engine.sv
// tb_systolic_tile_engine: directed tiles with a result scoreboard checked by an output monitor.
`timescale 1ns/1ps
module tb_systolic_tile_engine;
    localparam int ROWS = 8, COLS = 8, DW = 8, SW = 16, OC = 4, GROUPS = COLS / OC;
    typedef struct packed {
        logic [OC*SW-1:0] data;
        logic [0:0] grp;
        logic last;
    } beat_t;

    logic clk = 0, rst, start, busy, done, w_valid, w_ready, in_valid, in_ready, in_last;
    logic out_valid, out_ready, out_last;
    logic [COLS*DW-1:0] w_data;
    logic [ROWS*DW-1:0] in_data;
    logic [OC*SW-1:0] out_data, h_data;
    logic [0:0] out_group, h_grp;
    logic signed [DW-1:0] wm [ROWS][COLS];
    int xv [ROWS];
    int ev [COLS];
    beat_t exp_q [$];
    int n_chk = 0, n_fail = 0;
    bit bp = 0, held = 0;

    systolic_tile_engine #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .SUM_WIDTH(SW), .OUT_COLS(OC)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_group(out_group), .out_last(out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        out_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp ? ~out_ready : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst) held = 0;
        else begin
            if (held && out_valid) begin
                chk("stalled data stable", out_data, h_data);
                chk("stalled group stable", out_group, h_grp);
            end
            if (out_valid && !(out_ready && out_group == 1'(GROUPS-1)))
                chk("in_ready low while result pending", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected beat: got %0h expected none", out_data);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("beat data", out_data, b.data);
                    chk("beat group", out_group, b.grp);
                    chk("beat last", out_last, b.last);
                end
            end
            held = out_valid && !out_ready;
            h_data = out_data;
            h_grp = out_group;
        end
    end

    task automatic chk_zero();
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst w_ready", w_ready, 0);
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0);
        chk("rst out_group", out_group, 0);
        chk("rst out_last", out_last, 0);
    endtask

    // kind: 0 identity, 1 all ones, 2 diag(-3), 3 all 127, 4 anti-identity
    task automatic set_w(input int kind);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                wm[r][c] = kind == 0 ? DW'(r == c) : kind == 1 ? 8'sd1 : kind == 2 ? (r == c ? -8'sd3 : 8'sd0) :
                           kind == 3 ? 8'sd127 : DW'(r + c == ROWS - 1);
    endtask

    task automatic start_tile();
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
    endtask

    task automatic load_w();
        for (int j = 0; j < ROWS; j++) begin
            int n = 0;
            w_valid = 1;
            for (int c = 0; c < COLS; c++) w_data[c*DW +: DW] = wm[ROWS-1-j][c];
            @(negedge clk);
            while (!w_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("w_ready", w_ready, 1);
            @(posedge clk);
            #1;
        end
        w_valid = 0;
    endtask

    task automatic send(input bit last, input bit track);
        int n = 0;
        in_valid = 1;
        in_last = last;
        for (int r = 0; r < ROWS; r++) in_data[r*DW +: DW] = DW'(xv[r]);
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready", in_ready, 1);
        @(posedge clk);
        if (track)
            for (int g = 0; g < GROUPS; g++) begin
                beat_t b;
                b.grp = 1'(g);
                b.last = last && g == GROUPS - 1;
                for (int k = 0; k < OC; k++) b.data[k*SW +: SW] = SW'(ev[g*OC+k]);
                exp_q.push_back(b);
            end
        #1;
        in_valid = 0;
        in_last = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("done pulse", done, 1);
        chk("busy after done", busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1; start = 0; w_valid = 0; w_data = '0; in_valid = 0; in_data = '0; in_last = 0;
        repeat (3) @(negedge clk);
        chk_zero();
        @(posedge clk);
        #1;
        rst = 0;

        // Identity: result equals input, latency LAT+1 cycles.
        set_w(0); start_tile(); load_w();
        for (int r = 0; r < ROWS; r++) xv[r] = r + 1;
        for (int c = 0; c < COLS; c++) ev[c] = c + 1;
        send(1, 1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("first result latency", n, 16);
        wait_done();

        // All ones, three vectors, the last tagged.
        set_w(1); start_tile(); load_w();
        for (int r = 0; r < ROWS; r++) xv[r] = 2;
        for (int c = 0; c < COLS; c++) ev[c] = 16;
        send(0, 1);
        for (int r = 0; r < ROWS; r++) xv[r] = -1;
        for (int c = 0; c < COLS; c++) ev[c] = -8;
        send(0, 1);
        for (int r = 0; r < ROWS; r++) xv[r] = 127;
        for (int c = 0; c < COLS; c++) ev[c] = 1016;
        send(1, 1);
        wait_done();

        // Backpressure with diag(-3).
        bp = 1;
        set_w(2); start_tile(); load_w();
        xv = '{1, -2, 3, -4, 5, -6, 7, -8};
        ev = '{-3, 6, -9, 12, -15, 18, -21, 24};
        send(0, 1);
        xv = '{-4, -3, -2, -1, 0, 1, 2, 3};
        ev = '{12, 9, 6, 3, 0, -3, -6, -9};
        send(0, 1);
        xv = '{0, 0, 0, 0, 0, 0, 0, 0};
        ev = '{0, 0, 0, 0, 0, 0, 0, 0};
        send(0, 1);
        xv = '{127, -128, 127, -128, 127, -128, 127, -128};
        ev = '{-381, 384, -381, 384, -381, 384, -381, 384};
        send(1, 1);
        wait_done();
        bp = 0;

        // Accumulator overflow.
        set_w(3); start_tile(); load_w();
        for (int r = 0; r < ROWS; r++) xv[r] = 127;
`ifdef SYSTOLIC_ACC_SAT_EN
        for (int c = 0; c < COLS; c++) ev[c] = 32767;
`else
        for (int c = 0; c < COLS; c++) ev[c] = -2040;
`endif
        send(1, 1);
        wait_done();

        // Reset mid-tile discards in-flight vectors.
        set_w(1); start_tile(); load_w();
        for (int r = 0; r < ROWS; r++) xv[r] = 1;
        send(0, 0);
        send(0, 0);
        rst = 1;
        @(negedge clk);
        chk_zero();
        @(posedge clk);
        #1;
        rst = 0;
        set_w(4); start_tile(); load_w();
        for (int r = 0; r < ROWS; r++) xv[r] = r + 1;
        ev = '{8, 7, 6, 5, 4, 3, 2, 1};
        send(1, 1);
        wait_done();

        // start and w_valid asserted during COMPUTE are ignored.
        set_w(2); start_tile(); load_w();
        for (int r = 0; r < ROWS; r++) xv[r] = r + 1;
        ev = '{-3, -6, -9, -12, -15, -18, -21, -24};
        send(0, 1);
        start = 1;
        w_valid = 1;
        w_data = '1;
        for (int r = 0; r < ROWS; r++) xv[r] = 2 * r;
        ev = '{0, -6, -12, -18, -24, -30, -36, -42};
        send(0, 1);
        for (int r = 0; r < ROWS; r++) xv[r] = -1;
        for (int c = 0; c < COLS; c++) ev[c] = 3;
        send(1, 1);
        start = 0;
        w_valid = 0;
        wait_done();
        repeat (3) @(negedge clk);
        chk("idle after tile", busy, 0);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
